// File: rtl/bp_pkg.sv
// Shared types and helpers for the branch-prediction predecode slice.
package bp_pkg;

    typedef enum logic [2:0] {
        CF_NONE   = 3'd0,
        CF_BRANCH = 3'd1,
        CF_JAL    = 3'd2,
        CF_JALR   = 3'd3,
        CF_CALL   = 3'd4,
        CF_RET    = 3'd5,
        CF_CORET  = 3'd6
    } cf_type_e;

    localparam logic [6:0] OPC_JAL    = 7'b1101111;
    localparam logic [6:0] OPC_JALR   = 7'b1100111;
    localparam logic [6:0] OPC_BRANCH = 7'b1100011;

    // x1 (ra) and x5 (t0) are the architectural link registers
    function automatic logic is_link(input logic [4:0] reg_idx);
        return (reg_idx == 5'd1) || (reg_idx == 5'd5);
    endfunction

endpackage

// File: rtl/bp_cf_decode.sv
// Combinational control-flow classifier: type, sign-extended target offset, RVC flag.
// Compressed decoding is enabled with BP_PREDECODE_RVC_EN.
module bp_cf_decode
    import bp_pkg::*;
#(
    parameter int XLEN = 64,
    parameter int ILEN = 32
) (
    input  logic [ILEN-1:0] instr_i,
    output cf_type_e        cf_type_o,
    output logic [XLEN-1:0] imm_o,
    output logic            is_rvc_o,
    output logic            is_direct_o
);

    logic [20:0] j_imm_s;
    logic [12:0] b_imm_s;
    logic [4:0]  rd_s;
    logic [4:0]  rs1_s;

    assign j_imm_s = {instr_i[31], instr_i[19:12], instr_i[20], instr_i[30:21], 1'b0};
    assign b_imm_s = {instr_i[31], instr_i[7], instr_i[30:25], instr_i[11:8], 1'b0};
    assign rd_s    = instr_i[11:7];
    assign rs1_s   = instr_i[19:15];

`ifdef BP_PREDECODE_RVC_EN
    logic [11:0] cj_imm_s;
    logic [8:0]  cb_imm_s;
    logic [4:0]  c_rs1_s;
    logic [4:0]  c_rs2_s;

    assign cj_imm_s = {instr_i[12], instr_i[8], instr_i[10:9], instr_i[6], instr_i[7],
                       instr_i[2], instr_i[11], instr_i[5:3], 1'b0};
    assign cb_imm_s = {instr_i[12], instr_i[6:5], instr_i[2], instr_i[11:10], instr_i[4:3], 1'b0};
    assign c_rs1_s  = instr_i[11:7];
    assign c_rs2_s  = instr_i[6:2];
`endif

    // Classify the instruction and select the matching immediate
    always_comb begin
        cf_type_o   = CF_NONE;
        imm_o       = {XLEN{1'b0}};
        is_rvc_o    = 1'b0;
        is_direct_o = 1'b0;
        if (instr_i[1:0] == 2'b11) begin
            case (instr_i[6:0])
                OPC_JAL: begin
                    cf_type_o   = is_link(rd_s) ? CF_CALL : CF_JAL;
                    imm_o       = {{(XLEN-21){j_imm_s[20]}}, j_imm_s};
                    is_direct_o = 1'b1;
                end
                OPC_JALR: begin
                    if (is_link(rd_s) && !is_link(rs1_s)) begin
                        cf_type_o = CF_CALL;
                    end else if (!is_link(rd_s) && is_link(rs1_s)) begin
                        cf_type_o = CF_RET;
                    end else if (is_link(rd_s) && is_link(rs1_s)) begin
                        cf_type_o = (rd_s != rs1_s) ? CF_CORET : CF_CALL;
                    end else begin
                        cf_type_o = CF_JALR;
                    end
                end
                OPC_BRANCH: begin
                    cf_type_o = CF_BRANCH;
                    imm_o     = {{(XLEN-13){b_imm_s[12]}}, b_imm_s};
                end
                default: cf_type_o = CF_NONE;
            endcase
        end else begin
`ifdef BP_PREDECODE_RVC_EN
            is_rvc_o = 1'b1;
            case ({instr_i[15:13], instr_i[1:0]})
                5'b001_01: begin
                    // C.JAL only exists on RV32; on RV64 this slot is C.ADDIW
                    if (XLEN == 32) begin
                        cf_type_o   = CF_CALL;
                        imm_o       = {{(XLEN-12){cj_imm_s[11]}}, cj_imm_s};
                        is_direct_o = 1'b1;
                    end else begin
                        cf_type_o = CF_NONE;
                    end
                end
                5'b101_01: begin
                    cf_type_o   = CF_JAL;
                    imm_o       = {{(XLEN-12){cj_imm_s[11]}}, cj_imm_s};
                    is_direct_o = 1'b1;
                end
                5'b110_01, 5'b111_01: begin
                    cf_type_o = CF_BRANCH;
                    imm_o     = {{(XLEN-9){cb_imm_s[8]}}, cb_imm_s};
                end
                5'b100_10: begin
                    if ((c_rs1_s != 5'd0) && (c_rs2_s == 5'd0)) begin
                        if (!instr_i[12]) begin
                            cf_type_o = is_link(c_rs1_s) ? CF_RET : CF_JALR;
                        end else begin
                            cf_type_o = (c_rs1_s == 5'd5) ? CF_CORET : CF_CALL;
                        end
                    end else begin
                        cf_type_o = CF_NONE;
                    end
                end
                default: cf_type_o = CF_NONE;
            endcase
`else
            cf_type_o = CF_NONE;
`endif
        end
    end

endmodule

// File: rtl/bp_predecode.sv
// Fetch-side predecode: one-entry valid/ready register, RAS push/pop and next-PC prediction.
// Optional compressed-instruction support via BP_PREDECODE_RVC_EN.
module bp_predecode
    import bp_pkg::*;
#(
    parameter int XLEN = 64,
    parameter int ILEN = 32
) (
    input  logic            clk_i,
    input  logic            rst_i,
    input  logic            bp_flush_i,
    input  logic            in_vld_i,
    output logic            in_rdy_o,
    input  logic [XLEN-1:0] in_pc_i,
    input  logic [ILEN-1:0] in_instr_i,
    output logic            out_vld_o,
    input  logic            out_rdy_i,
    output logic [XLEN-1:0] out_pc_o,
    output logic [ILEN-1:0] out_instr_o,
    output logic [2:0]      out_cf_type_o,
    output logic            redirect_o,
    output logic [XLEN-1:0] pred_pc_o,
    input  logic            ras_data_vld_i,
    input  logic [XLEN-1:0] ras_data_i,
    output logic            ras_push_o,
    output logic            ras_pop_o,
    output logic [XLEN-1:0] ras_data_o
);

    cf_type_e        dec_type_s;
    logic [XLEN-1:0] dec_imm_s;
    logic            dec_rvc_s;
    logic            dec_direct_s;

    logic            vld_r;
    logic [XLEN-1:0] pc_r;
    logic [ILEN-1:0] instr_r;
    cf_type_e        type_r;
    logic [XLEN-1:0] imm_r;
    logic            rvc_r;
    logic            direct_r;

    logic            accept_s;
    logic            fire_s;
    logic [XLEN-1:0] seq_pc_s;
    logic [XLEN-1:0] tgt_pc_s;
    logic [XLEN-1:0] pred_s;
    logic            redir_s;

    bp_cf_decode #(.XLEN(XLEN), .ILEN(ILEN)) u_cf_decode (
        .instr_i     (in_instr_i),
        .cf_type_o   (dec_type_s),
        .imm_o       (dec_imm_s),
        .is_rvc_o    (dec_rvc_s),
        .is_direct_o (dec_direct_s)
    );

    assign in_rdy_o = ~vld_r | out_rdy_i;
    assign accept_s = in_vld_i & in_rdy_o & ~bp_flush_i;
    assign fire_s   = vld_r & out_rdy_i & ~bp_flush_i;

    // Pipeline register: flush beats accept, accept beats drain
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            vld_r    <= 1'b0;
            pc_r     <= {XLEN{1'b0}};
            instr_r  <= {ILEN{1'b0}};
            type_r   <= CF_NONE;
            imm_r    <= {XLEN{1'b0}};
            rvc_r    <= 1'b0;
            direct_r <= 1'b0;
        end else begin
            if (bp_flush_i) begin
                vld_r <= 1'b0;
            end else if (accept_s) begin
                vld_r <= 1'b1;
            end else if (fire_s) begin
                vld_r <= 1'b0;
            end else begin
                vld_r <= vld_r;
            end
            if (accept_s) begin
                pc_r     <= in_pc_i;
                instr_r  <= in_instr_i;
                type_r   <= dec_type_s;
                imm_r    <= dec_imm_s;
                rvc_r    <= dec_rvc_s;
                direct_r <= dec_direct_s;
            end else begin
                pc_r     <= pc_r;
                instr_r  <= instr_r;
                type_r   <= type_r;
                imm_r    <= imm_r;
                rvc_r    <= rvc_r;
                direct_r <= direct_r;
            end
        end
    end

    assign seq_pc_s = pc_r + (rvc_r ? XLEN'(3'd2) : XLEN'(3'd4));
    assign tgt_pc_s = pc_r + imm_r;

    // Next-PC prediction; backward branches are predicted taken
    always_comb begin
        pred_s  = seq_pc_s;
        redir_s = 1'b0;
        case (type_r)
            CF_JAL, CF_CALL: begin
                if (direct_r) begin
                    pred_s  = tgt_pc_s;
                    redir_s = 1'b1;
                end else begin
                    pred_s  = seq_pc_s;
                    redir_s = 1'b0;
                end
            end
            CF_BRANCH: begin
                if (imm_r[XLEN-1]) begin
                    pred_s  = tgt_pc_s;
                    redir_s = 1'b1;
                end else begin
                    pred_s  = seq_pc_s;
                    redir_s = 1'b0;
                end
            end
            CF_RET, CF_CORET: begin
                if (ras_data_vld_i) begin
                    pred_s  = ras_data_i;
                    redir_s = 1'b1;
                end else begin
                    pred_s  = seq_pc_s;
                    redir_s = 1'b0;
                end
            end
            default: begin
                pred_s  = seq_pc_s;
                redir_s = 1'b0;
            end
        endcase
    end

    assign out_vld_o     = vld_r;
    assign out_pc_o      = pc_r;
    assign out_instr_o   = instr_r;
    assign out_cf_type_o = type_r;
    assign pred_pc_o     = vld_r ? pred_s : {XLEN{1'b0}};
    assign redirect_o    = vld_r & redir_s;
    // Strobes are tied to the handshake so a stalled entry never re-pushes
    assign ras_push_o    = fire_s & ((type_r == CF_CALL) | (type_r == CF_CORET));
    assign ras_pop_o     = fire_s & ((type_r == CF_RET)  | (type_r == CF_CORET));
    assign ras_data_o    = vld_r ? seq_pc_s : {XLEN{1'b0}};

endmodule
